// File: rtl/csi_rx_lane_deskew_if.sv
// Byte-lane bus between the per-lane byte aligners, the deskew stage and
// the CSI packet handler. The master drives the raw lanes and consumes the
// deskewed word; the slave (the deskew stage) does the opposite.
interface csi_rx_lane_deskew_if #(
    parameter int N_LANES = 4
) ();
    logic [8*N_LANES-1:0] word_in;
    logic [N_LANES-1:0]   valid_in;
    logic [8*N_LANES-1:0] word_out;
    logic                 valid_out;

    modport master (
        output word_in,
        output valid_in,
        input  word_out,
        input  valid_out
    );

    modport slave (
        input  word_in,
        input  valid_in,
        output word_out,
        output valid_out
    );
endinterface

// File: rtl/csi_rx_lane_deskew.sv
// Lane-to-lane deskew for a CSI receiver. Each lane gets a delay tap chosen
// from how long it has already been valid when all enabled lanes first agree;
// taps stay locked until packet_done. Over-range skew pulses skew_err,
// resets the byte aligners and bumps a saturating counter.
module csi_rx_lane_deskew #(
    parameter int N_LANES  = 4,
    parameter int MAX_SKEW = 3,
    parameter int CNT_W    = 8
) (
    input  logic                   byte_clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   packet_done,
    input  logic                   wait_for_sync,
    input  logic [N_LANES-1:0]     lane_mask,
    csi_rx_lane_deskew_if.slave    bus,
    output logic                   packet_done_out,
    output logic [3*N_LANES-1:0]   taps_out,
    output logic                   skew_err,
    output logic [CNT_W-1:0]       skew_err_cnt
);

    localparam int RUN_W = 4;
    localparam int TAP_W = 3;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_SKEW + 1);
    localparam logic [RUN_W-1:0] SKEW_MAX = RUN_W'(MAX_SKEW);

    localparam logic [0:0] ST_SEEK   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [N_LANES-1:0] mask_q, mask_d;
    logic [RUN_W-1:0]   run_q [N_LANES];
    logic [RUN_W-1:0]   run_d [N_LANES];
    logic [TAP_W-1:0]   tap_q [N_LANES];
    logic [TAP_W-1:0]   tap_d [N_LANES];
    logic [TAP_W-1:0]   tap_new [N_LANES];
    logic [TAP_W-1:0]   tap_nxt [N_LANES];
    logic [7:0]         pipe_q [MAX_SKEW][N_LANES];
    logic [7:0]         pipe_d [MAX_SKEW][N_LANES];
    logic [8*N_LANES-1:0] word_out_q, word_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_LANES-1:0] mask_eff;
    logic               all_vld;
    logic               over_range;
    logic               lock;

    // Lane qualification: effective mask, all-valid, over-range skew and lock decision
    always_comb begin
        mask_eff   = (state_q == ST_LOCKED) ? mask_q : lane_mask;
        all_vld    = (mask_eff != '0) && (&(bus.valid_in | ~mask_eff));
        over_range = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            if (mask_eff[i] && bus.valid_in[i] && (run_q[i] > SKEW_MAX)) begin
                over_range = 1'b1;
            end
        end
        skew_err        = enable && (state_q == ST_SEEK) && !all_vld && over_range;
        packet_done_out = packet_done | skew_err;
        lock            = enable && (state_q == ST_SEEK) && wait_for_sync && all_vld
                          && !packet_done && !skew_err;
    end

    // Candidate taps (current run clipped to MAX_SKEW) and the tap set in force this cycle
    always_comb begin
        logic [RUN_W-1:0] run_cur;
        for (int i = 0; i < N_LANES; i++) begin
            run_cur = bus.valid_in[i] ? run_q[i] : '0;
            if (run_cur > SKEW_MAX) begin
                run_cur = SKEW_MAX;
            end
            tap_new[i] = mask_eff[i] ? run_cur[TAP_W-1:0] : '0;
            tap_nxt[i] = lock ? tap_new[i] : tap_q[i];
        end
    end

    // Delay line shift and per-lane tap select into the output word
    always_comb begin
        logic [7:0] sel;
        for (int i = 0; i < N_LANES; i++) begin
            pipe_d[0][i] = bus.word_in[8*i +: 8];
            for (int k = 1; k < MAX_SKEW; k++) begin
                pipe_d[k][i] = pipe_q[k-1][i];
            end
        end
        word_out_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            sel = bus.word_in[8*i +: 8];
            for (int k = 1; k <= MAX_SKEW; k++) begin
                if (tap_nxt[i] == TAP_W'(k)) begin
                    sel = pipe_q[k-1][i];
                end
            end
            word_out_d[8*i +: 8] = mask_eff[i] ? sel : 8'h00;
        end
    end

    // Next-state for lock FSM, latched mask/taps, run counters and error counter
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_LOCKED) && packet_done) begin
            state_d = ST_SEEK;
        end else if (lock) begin
            state_d = ST_LOCKED;
        end
        mask_d = lock ? lane_mask : mask_q;
        for (int i = 0; i < N_LANES; i++) begin
            tap_d[i] = tap_nxt[i];
            if (!bus.valid_in[i]) begin
                run_d[i] = '0;
            end else if (run_q[i] == RUN_MAX) begin
                run_d[i] = run_q[i];
            end else begin
                run_d[i] = run_q[i] + RUN_W'(1);
            end
        end
        cnt_d = (skew_err && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Control state: reset to SEEK with cleared taps and counters, else advance on enable
    always_ff @(posedge byte_clock) begin
        if (reset) begin
            state_q <= ST_SEEK;
            mask_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                run_q[i] <= '0;
                tap_q[i] <= '0;
            end
        end else if (enable) begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            tap_q   <= tap_d;
        end
    end

    // Datapath: delay line and output word carry no reset
    always_ff @(posedge byte_clock) begin
        if (enable) begin
            pipe_q     <= pipe_d;
            word_out_q <= word_out_d;
        end
    end

    // Output packing
    always_comb begin
        taps_out = '0;
        for (int i = 0; i < N_LANES; i++) begin
            taps_out[3*i +: 3] = tap_q[i];
        end
        bus.word_out  = word_out_q;
        bus.valid_out = (state_q == ST_LOCKED);
        skew_err_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_csi_rx_lane_deskew.sv
// Bench for csi_rx_lane_deskew: directed lock/skew/mask/enable/reset scenarios
// followed by randomized traffic, all checked every cycle against a
// history-based model of the deskew rules.
module tb_csi_rx_lane_deskew;
    localparam int N  = 4;
    localparam int MS = 3;
    localparam int CW = 8;

    logic           byte_clock = 1'b0;
    logic           reset;
    logic           enable;
    logic           packet_done;
    logic           wait_for_sync;
    logic [N-1:0]   lane_mask;
    logic           packet_done_out;
    logic [3*N-1:0] taps_out;
    logic           skew_err;
    logic [CW-1:0]  skew_err_cnt;

    csi_rx_lane_deskew_if #(.N_LANES(N)) bus ();

    csi_rx_lane_deskew #(.N_LANES(N), .MAX_SKEW(MS), .CNT_W(CW)) dut (
        .byte_clock      (byte_clock),
        .reset           (reset),
        .enable          (enable),
        .packet_done     (packet_done),
        .wait_for_sync   (wait_for_sync),
        .lane_mask       (lane_mask),
        .bus             (bus),
        .packet_done_out (packet_done_out),
        .taps_out        (taps_out),
        .skew_err        (skew_err),
        .skew_err_cnt    (skew_err_cnt)
    );

    always #5 byte_clock = ~byte_clock;

    int n_tests = 0;
    int n_fail  = 0;
    int n_err_seen = 0;
    logic obs_err, obs_pdo;

    // Model: lock flag, latched mask/taps, error count, expected word, and
    // histories of past (enabled) valid vectors and words.
    bit           m_locked = 0;
    logic [N-1:0] m_mask = '0;
    int           m_taps [N];
    int           m_cnt = 0;
    logic [8*N-1:0] m_word = '0;
    bit           m_word_ok = 0;
    logic [N-1:0]   vh [$];
    logic [8*N-1:0] wh [$];
    int           seq [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] eff_mask();
        return m_locked ? m_mask : lane_mask;
    endfunction

    // Consecutive earlier valid cycles of lane i, provided it is valid now.
    function automatic int run_of(input int i);
        int n;
        logic [N-1:0] v;
        if (!bus.valid_in[i]) return 0;
        n = 0;
        for (int j = vh.size() - 1; j >= 0; j--) begin
            v = vh[j];
            if (v[i]) n++;
            else break;
        end
        return (n > MS + 1) ? MS + 1 : n;
    endfunction

    function automatic bit all_valid(input logic [N-1:0] me);
        if (me == '0) return 0;
        for (int i = 0; i < N; i++) if (me[i] && !bus.valid_in[i]) return 0;
        return 1;
    endfunction

    function automatic bit over_range();
        logic [N-1:0] me;
        if (m_locked) return 0;
        me = eff_mask();
        if (all_valid(me)) return 0;
        for (int i = 0; i < N; i++) if (me[i] && run_of(i) > MS) return 1;
        return 0;
    endfunction

    task automatic tick();
        bit e_err, e_pdo, lock;
        logic [N-1:0] me;
        int tn [N];
        logic [8*N-1:0] nw, hw;
        logic [3*N-1:0] et;
        e_err = enable && !reset && over_range();
        e_pdo = packet_done | e_err;
        #1;
        obs_err = skew_err;
        obs_pdo = packet_done_out;
        if (!reset) begin
            chk("skew_err", 64'(skew_err), 64'(e_err));
            chk("packet_done_out", 64'(packet_done_out), 64'(e_pdo));
        end
        if (skew_err) n_err_seen++;
        @(posedge byte_clock);
        if (reset) begin
            m_locked = 0;
            m_cnt = 0;
            for (int i = 0; i < N; i++) m_taps[i] = 0;
            vh.delete();
            if (enable) wh.push_back(bus.word_in);
        end else if (enable) begin
            me = eff_mask();
            lock = !m_locked && wait_for_sync && all_valid(me) && !packet_done && !e_err;
            for (int i = 0; i < N; i++) begin
                if (lock) tn[i] = me[i] ? ((run_of(i) > MS) ? MS : run_of(i)) : 0;
                else      tn[i] = m_taps[i];
            end
            m_word_ok = 1;
            nw = '0;
            for (int i = 0; i < N; i++) begin
                if (!me[i])          nw[8*i +: 8] = 8'h00;
                else if (tn[i] == 0) nw[8*i +: 8] = bus.word_in[8*i +: 8];
                else if (wh.size() >= tn[i]) begin
                    hw = wh[wh.size() - tn[i]];
                    nw[8*i +: 8] = hw[8*i +: 8];
                end else m_word_ok = 0;
            end
            m_word = nw;
            if (m_locked && packet_done) m_locked = 0;
            else if (lock) begin
                m_locked = 1;
                m_mask = lane_mask;
                m_taps = tn;
            end
            if (e_err && m_cnt < (2**CW) - 1) m_cnt++;
            vh.push_back(bus.valid_in);
            wh.push_back(bus.word_in);
            if (vh.size() > 16) void'(vh.pop_front());
            if (wh.size() > 16) void'(wh.pop_front());
        end
        @(negedge byte_clock);
        et = '0;
        for (int i = 0; i < N; i++) et[3*i +: 3] = 3'(m_taps[i]);
        chk("valid_out", 64'(bus.valid_out), 64'(m_locked));
        chk("taps_out", 64'(taps_out), 64'(et));
        chk("skew_err_cnt", 64'(skew_err_cnt), 64'(m_cnt));
        if (m_locked && m_word_ok) chk("word_out", 64'(bus.word_out), 64'(m_word));
    endtask

    // Lane byte = {1, lane, per-lane sequence} while valid, noise otherwise.
    task automatic set_lanes(input logic [N-1:0] v);
        logic [8*N-1:0] w;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                w[8*i +: 8] = {1'b1, 3'(i), 4'(seq[i])};
                seq[i]++;
            end else w[8*i +: 8] = 8'($urandom);
        end
        bus.valid_in = v;
        bus.word_in  = w;
    endtask

    task automatic reset_seq();
        for (int i = 0; i < N; i++) seq[i] = 0;
    endtask

    task automatic idle(input int n);
        packet_done = 0;
        for (int k = 0; k < n; k++) begin
            set_lanes('0);
            tick();
        end
    endtask

    task automatic run_starts(input int s0, input int s1, input int s2, input int s3, input int ncyc);
        int st [N];
        logic [N-1:0] v;
        st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < N; i++) v[i] = (c >= st[i]);
            set_lanes(v);
            tick();
        end
    endtask

    initial begin
        int d [N];
        int maxd, len, errs0;
        logic [N-1:0] v;
        logic [8*N-1:0] w_hold;
        logic [3:0] masks [3];
        masks[0] = 4'h1; masks[1] = 4'h3; masks[2] = 4'hF;
        for (int i = 0; i < N; i++) m_taps[i] = 0;
        reset = 1; enable = 1; packet_done = 0; wait_for_sync = 1; lane_mask = 4'hF;
        reset_seq();
        set_lanes('0);
        @(negedge byte_clock);
        for (int k = 0; k < 3; k++) tick();
        reset = 0;
        chk("reset valid_out", 64'(bus.valid_out), 64'd0);
        chk("reset taps_out", 64'(taps_out), 64'd0);
        chk("reset cnt", 64'(skew_err_cnt), 64'd0);

        // T1: lanes 0..3 rise at t, t+1, t+3, t+2
        reset_seq();
        run_starts(0, 1, 3, 2, 4);
        chk("T1 valid_out", 64'(bus.valid_out), 64'd1);
        chk("T1 taps", 64'(taps_out), 64'h213);
        chk("T1 header", 64'(bus.word_out), 64'hB0A09080);
        packet_done = 1; set_lanes('0); tick(); packet_done = 0;
        chk("T1 end", 64'(bus.valid_out), 64'd0);
        idle(2);

        // T2: lane2 late enough that lane0 reaches run 4 before all lanes agree
        reset_seq();
        errs0 = n_err_seen;
        run_starts(0, 1, 5, 2, 5);
        chk("T2 skew_err", 64'(obs_err), 64'd1);
        chk("T2 pdo", 64'(obs_pdo), 64'd1);
        chk("T2 pulses", 64'(n_err_seen - errs0), 64'd1);
        chk("T2 cnt", 64'(skew_err_cnt), 64'd1);
        chk("T2 no lock", 64'(bus.valid_out), 64'd0);
        idle(2);

        // T3: two-lane mask
        lane_mask = 4'b0011; reset_seq();
        run_starts(0, 1, 99, 99, 2);
        chk("T3 valid_out", 64'(bus.valid_out), 64'd1);
        chk("T3 taps", 64'(taps_out), 64'h001);
        chk("T3 word", 64'(bus.word_out), 64'h00009080);

        // T4: mask and valid changes while locked are ignored
        lane_mask = 4'h0;
        for (int k = 0; k < 3; k++) begin set_lanes('0); tick(); end
        chk("T4 hold", 64'(bus.valid_out), 64'd1);
        packet_done = 1; tick(); packet_done = 0;
        chk("T4 unlock", 64'(bus.valid_out), 64'd0);
        lane_mask = 4'hF; reset_seq();
        set_lanes(4'hF); tick();
        chk("T4 relock", 64'(bus.valid_out), 64'd1);
        chk("T4 relock word", 64'(bus.word_out), 64'hB0A09080);
        packet_done = 1; set_lanes('0); tick();
        idle(2);

        // T5: packet_done beats lock; enable low freezes outputs
        reset_seq();
        packet_done = 1; set_lanes(4'hF); tick(); packet_done = 0;
        chk("T5 no lock", 64'(bus.valid_out), 64'd0);
        set_lanes(4'hF); tick();
        chk("T5 lock", 64'(bus.valid_out), 64'd1);
        chk("T5 taps", 64'(taps_out), 64'h249);
        chk("T5 word", 64'(bus.word_out), 64'hB0A09080);
        w_hold = bus.word_out;
        enable = 0;
        for (int k = 0; k < 3; k++) begin
            set_lanes(4'($urandom)); tick();
            chk("T5 frozen word", 64'(bus.word_out), 64'(w_hold));
            chk("T5 frozen valid", 64'(bus.valid_out), 64'd1);
        end
        enable = 1;
        packet_done = 1; set_lanes('0); tick();
        idle(2);

        // T6: counter saturation, then reset mid-packet
        for (int k = 0; k < 304; k++) begin set_lanes(4'b0001); tick(); end
        chk("T6 saturate", 64'(skew_err_cnt), 64'd255);
        set_lanes(4'hF); tick();
        chk("T6 locked", 64'(bus.valid_out), 64'd1);
        reset = 1; tick(); reset = 0;
        chk("T6 reset valid", 64'(bus.valid_out), 64'd0);
        chk("T6 reset cnt", 64'(skew_err_cnt), 64'd0);
        idle(2);

        // Randomized packets with jittered lane starts, enable gaps and mask changes
        for (int ep = 0; ep < 80; ep++) begin
            lane_mask = ($urandom % 4 == 0) ? 4'($urandom) : masks[$urandom_range(0, 2)];
            maxd = 0;
            for (int i = 0; i < N; i++) begin
                d[i] = $urandom_range(0, MS + 2);
                if (d[i] > maxd) maxd = d[i];
            end
            len = $urandom_range(3, 15);
            for (int c = 0; c < maxd + len + 2; c++) begin
                enable        = ($urandom % 10) != 0;
                wait_for_sync = ($urandom % 8) != 0;
                packet_done   = (c == maxd + len) || ($urandom % 40 == 0);
                reset         = ($urandom % 300) == 0;
                if ($urandom % 25 == 0) lane_mask = 4'($urandom);
                for (int i = 0; i < N; i++) begin
                    v[i] = (c >= d[i]) && (c < maxd + len);
                    if ($urandom % 30 == 0) v[i] = ~v[i];
                end
                bus.valid_in = v;
                bus.word_in  = $urandom;
                tick();
            end
            reset = 0; enable = 1;
            idle(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
